// File: rtl/mips_instr_encoder_if.sv
// Command and output-word bundle for the MIPS instruction encoder.
// master drives commands and consumes words; slave is the encoder.
interface mips_instr_encoder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_kind;
    logic [4:0]        cmd_rs;
    logic [4:0]        cmd_rt;
    logic [4:0]        cmd_rd;
    logic [5:0]        cmd_funct;
    logic [25:0]       cmd_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;
    logic              err;
    logic [15:0]       word_count;

    modport master (
        output start, base_addr, cmd_valid, cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_funct,
               cmd_imm, out_ready,
        input  cmd_ready, out_valid, out_word, out_addr, err, word_count
    );

    modport slave (
        input  start, base_addr, cmd_valid, cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_funct,
               cmd_imm, out_ready,
        output cmd_ready, out_valid, out_word, out_addr, err, word_count
    );
endinterface

// File: rtl/mips_instr_encoder.sv
// Encodes symbolic MIPS commands into 32-bit machine words with word addresses.
// BLT/BGE expand to slt + bne/beq through the AT_REG scratch register.
module mips_instr_encoder #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned AT_REG = 1
) (
    input logic                 clk,
    input logic                 reset,
    mips_instr_encoder_if.slave bus
);
    localparam logic [3:0] KRtype = 4'd0,  KLw   = 4'd1,  KSw   = 4'd2,  KLb   = 4'd3;
    localparam logic [3:0] KSb    = 4'd4,  KBeq  = 4'd5,  KBne  = 4'd6,  KAddi = 4'd7;
    localparam logic [3:0] KAndi  = 4'd8,  KOri  = 4'd9,  KXori = 4'd10, KJ    = 4'd11;
    localparam logic [3:0] KJr    = 4'd12, KJalr = 4'd13, KBlt  = 4'd14, KBge  = 4'd15;
    localparam logic [4:0] AtReg  = 5'(AT_REG);

    typedef enum logic {StIdle, StPend} state_e;

    state_e            state;
    logic              out_valid;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;
    logic              err;
    logic [15:0]       word_count;
    logic [ADDR_W-1:0] addr_cnt;
    logic [31:0]       pend_word;

    logic [15:0] imm;
    logic [15:0] imm_m1;
    logic [31:0] word1;
    logic [31:0] word2;
    logic        is_pseudo;
    logic        is_bad;
    logic        cmd_ready;
    logic        accept;
    logic        out_hs;

    assign imm    = bus.cmd_imm[15:0];
    // Second word sits one slot later, so the branch offset shrinks by one.
    assign imm_m1 = imm - 16'd1;

    always_comb begin
        word1     = '0;
        word2     = '0;
        is_pseudo = 1'b0;
        case (bus.cmd_kind)
            KRtype: word1 = {6'b000000, bus.cmd_rs, bus.cmd_rt, bus.cmd_rd, 5'b00000,
                             bus.cmd_funct};
            KLw:    word1 = {6'b100011, bus.cmd_rs, bus.cmd_rt, imm};
            KSw:    word1 = {6'b101011, bus.cmd_rs, bus.cmd_rt, imm};
            KLb:    word1 = {6'b100000, bus.cmd_rs, bus.cmd_rt, imm};
            KSb:    word1 = {6'b101000, bus.cmd_rs, bus.cmd_rt, imm};
            KBeq:   word1 = {6'b000100, bus.cmd_rs, bus.cmd_rt, imm};
            KBne:   word1 = {6'b000101, bus.cmd_rs, bus.cmd_rt, imm};
            KAddi:  word1 = {6'b001000, bus.cmd_rs, bus.cmd_rt, imm};
            KAndi:  word1 = {6'b001100, bus.cmd_rs, bus.cmd_rt, imm};
            KOri:   word1 = {6'b001101, bus.cmd_rs, bus.cmd_rt, imm};
            KXori:  word1 = {6'b001110, bus.cmd_rs, bus.cmd_rt, imm};
            KJ:     word1 = {6'b000010, bus.cmd_imm};
            KJr:    word1 = {6'b000000, bus.cmd_rs, 15'b0, 6'b001000};
            KJalr:  word1 = {6'b000000, bus.cmd_rs, 5'b00000, bus.cmd_rd, 5'b00000,
                             6'b001001};
            KBlt: begin
                word1     = {6'b000000, bus.cmd_rs, bus.cmd_rt, AtReg, 5'b00000, 6'b101010};
                word2     = {6'b000101, AtReg, 5'b00000, imm_m1};
                is_pseudo = 1'b1;
            end
            KBge: begin
                word1     = {6'b000000, bus.cmd_rs, bus.cmd_rt, AtReg, 5'b00000, 6'b101010};
                word2     = {6'b000100, AtReg, 5'b00000, imm_m1};
                is_pseudo = 1'b1;
            end
            default: word1 = '0;
        endcase
    end

    assign is_bad    = is_pseudo && (imm == 16'h8000);
    assign cmd_ready = (state == StIdle) && !bus.start && (!out_valid || bus.out_ready);
    assign accept    = bus.cmd_valid && cmd_ready;
    assign out_hs    = out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            out_valid  <= 1'b0;
            out_word   <= '0;
            out_addr   <= '0;
            err        <= 1'b0;
            word_count <= '0;
            addr_cnt   <= '0;
            pend_word  <= '0;
        end else begin
            err <= 1'b0;
            if (bus.start) begin
                state      <= StIdle;
                out_valid  <= 1'b0;
                addr_cnt   <= bus.base_addr;
                word_count <= '0;
            end else begin
                if (out_hs && (word_count != 16'hFFFF)) begin
                    word_count <= word_count + 16'd1;
                end
                if (state == StPend) begin
                    // Word1 is always valid here; word2 follows with no bubble.
                    if (out_hs) begin
                        out_word <= pend_word;
                        out_addr <= addr_cnt;
                        addr_cnt <= addr_cnt + 1'b1;
                        state    <= StIdle;
                    end
                end else if (accept) begin
                    if (is_bad) begin
                        err <= 1'b1;
                        if (out_hs) out_valid <= 1'b0;
                    end else begin
                        out_valid <= 1'b1;
                        out_word  <= word1;
                        out_addr  <= addr_cnt;
                        addr_cnt  <= addr_cnt + 1'b1;
                        if (is_pseudo) begin
                            pend_word <= word2;
                            state     <= StPend;
                        end
                    end
                end else if (out_hs) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_word   = out_word;
    assign bus.out_addr   = out_addr;
    assign bus.err        = err;
    assign bus.word_count = word_count;
endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed-vector bench for mips_instr_encoder with hand-computed expected words.
module tb_mips_instr_encoder;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mips_instr_encoder_if #(.ADDR_W(8)) bus ();

    mips_instr_encoder #(.ADDR_W(8), .AT_REG(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [5:0] funct,
                           input logic [25:0] imm);
        bus.cmd_valid = 1'b1;
        bus.cmd_kind  = kind;
        bus.cmd_rs    = rs;
        bus.cmd_rt    = rt;
        bus.cmd_rd    = rd;
        bus.cmd_funct = funct;
        bus.cmd_imm   = imm;
    endtask

    task automatic do_start(input logic [7:0] base);
        bus.start     = 1'b1;
        bus.base_addr = base;
        #1;
        check("start_blocks_ready", 32'(bus.cmd_ready), 32'd0);
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_kind  = '0;
        bus.cmd_rs    = '0;
        bus.cmd_rt    = '0;
        bus.cmd_rd    = '0;
        bus.cmd_funct = '0;
        bus.cmd_imm   = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_word", bus.out_word, 32'h0);
        check("rst_addr", 32'(bus.out_addr), 32'h0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_count", 32'(bus.word_count), 32'd0);
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);

        // LW
        do_start(8'h10);
        set_cmd(4'd1, 5'd2, 5'd3, 5'd0, 6'd0, 26'h0004);
        #1;
        check("lw_ready", 32'(bus.cmd_ready), 32'd1);
        step();
        bus.cmd_valid = 1'b0;
        check("lw_valid", 32'(bus.out_valid), 32'd1);
        check("lw_word", bus.out_word, 32'h8C430004);
        check("lw_addr", 32'(bus.out_addr), 32'h10);
        step();
        check("lw_count", 32'(bus.word_count), 32'd1);
        check("lw_drain", 32'(bus.out_valid), 32'd0);

        // ADDI then J back-to-back
        do_start(8'h10);
        set_cmd(4'd7, 5'd0, 5'd8, 5'd0, 6'd0, 26'h000FFFF);
        step();
        check("addi_word", bus.out_word, 32'h2008FFFF);
        check("addi_addr", 32'(bus.out_addr), 32'h10);
        set_cmd(4'd11, 5'd0, 5'd0, 5'd0, 6'd0, 26'h0000010);
        #1;
        check("j_ready", 32'(bus.cmd_ready), 32'd1);
        step();
        check("j_word", bus.out_word, 32'h08000010);
        check("j_addr", 32'(bus.out_addr), 32'h11);

        // BLT then BGE
        set_cmd(4'd14, 5'd4, 5'd5, 5'd0, 6'd0, 26'h0003);
        step();
        check("blt_w1", bus.out_word, 32'h0085082A);
        check("blt_a1", 32'(bus.out_addr), 32'h12);
        check("blt_pend_ready", 32'(bus.cmd_ready), 32'd0);
        step();
        check("blt_w2", bus.out_word, 32'h14200002);
        check("blt_a2", 32'(bus.out_addr), 32'h13);
        set_cmd(4'd15, 5'd4, 5'd5, 5'd0, 6'd0, 26'h0003);
        step();
        check("bge_w1", bus.out_word, 32'h0085082A);
        check("bge_a1", 32'(bus.out_addr), 32'h14);
        step();
        check("bge_w2", bus.out_word, 32'h10200002);
        check("bge_a2", 32'(bus.out_addr), 32'h15);

        // BGE overflow error
        set_cmd(4'd15, 5'd4, 5'd5, 5'd0, 6'd0, 26'h8000);
        step();
        bus.cmd_valid = 1'b0;
        check("err_pulse", 32'(bus.err), 32'd1);
        check("err_novalid", 32'(bus.out_valid), 32'd0);
        step();
        check("err_clear", 32'(bus.err), 32'd0);
        set_cmd(4'd9, 5'd1, 5'd2, 5'd0, 6'd0, 26'h1234);
        step();
        check("ori_word", bus.out_word, 32'h34221234);
        check("ori_addr", 32'(bus.out_addr), 32'h16);

        // JALR with 3-cycle stall
        set_cmd(4'd13, 5'd31, 5'd0, 5'd4, 6'd0, 26'h0);
        step();
        check("jalr_word", bus.out_word, 32'h03E02009);
        check("jalr_addr", 32'(bus.out_addr), 32'h17);
        bus.out_ready = 1'b0;
        set_cmd(4'd0, 5'd1, 5'd2, 5'd3, 6'h20, 26'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ready", 32'(bus.cmd_ready), 32'd0);
            step();
            check("stall_word", bus.out_word, 32'h03E02009);
            check("stall_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.cmd_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("stall_drain", 32'(bus.out_valid), 32'd0);
        check("count8", 32'(bus.word_count), 32'd8);

        // start during PEND drops word2
        set_cmd(4'd14, 5'd4, 5'd5, 5'd0, 6'd0, 26'h0003);
        step();
        bus.cmd_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("pend_w1", bus.out_word, 32'h0085082A);
        do_start(8'h40);
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_count", 32'(bus.word_count), 32'd0);
        bus.out_ready = 1'b1;
        set_cmd(4'd0, 5'd1, 5'd2, 5'd3, 6'h20, 26'h0);
        step();
        bus.cmd_valid = 1'b0;
        check("abort_word", bus.out_word, 32'h00221820);
        check("abort_addr", 32'(bus.out_addr), 32'h40);
        step();

        // address wrap
        do_start(8'hFF);
        set_cmd(4'd0, 5'd1, 5'd2, 5'd3, 6'h20, 26'h0);
        step();
        check("wrap_a0", 32'(bus.out_addr), 32'hFF);
        set_cmd(4'd0, 5'd1, 5'd2, 5'd4, 6'h22, 26'h0);
        step();
        bus.cmd_valid = 1'b0;
        check("wrap_w1", bus.out_word, 32'h00222022);
        check("wrap_a1", 32'(bus.out_addr), 32'h00);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Reverse of the main decoder: turns a stream of symbolic instruction commands (kind + register fields + immediate) into 32-bit MIPS machine words.
- Each word is presented with a word address, so a loader or testbench can fill instruction memory for the single-cycle/baseline CPU.
- Emits only encodings the decoder supports, plus two pseudo-instructions (BLT, BGE) that expand to two words.

Parameters:
- ADDR_W, 8, width of the word-address counter.
- AT_REG, 1, scratch register used by the pseudo-instruction expansions.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- start  in  1  synchronous: load address counter with base_addr, abort any pending word
- base_addr  in  ADDR_W  start address
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_kind  in  4  0 RTYPE, 1 LW, 2 SW, 3 LB, 4 SB, 5 BEQ, 6 BNE, 7 ADDI, 8 ANDI, 9 ORI, 10 XORI, 11 J, 12 JR, 13 JALR, 14 BLT, 15 BGE
- cmd_rs, cmd_rt, cmd_rd  in  5 each  register fields
- cmd_funct  in  6  R-type funct (RTYPE only)
- cmd_imm  in  26  J target [25:0]; all others use [15:0]
- out_valid  out  1  word/address valid
- out_ready  in  1  consumer accepts
- out_word  out  32  encoded instruction
- out_addr  out  ADDR_W  word address of out_word
- err  out  1  one-cycle pulse: command rejected
- word_count  out  16  words handed off since reset/start (saturates at FFFF)

Behaviour:
- Reset: out_valid=0, out_word=0, out_addr=0, err=0, word_count=0, FSM=IDLE, address counter=0.
- FSM states:
  - IDLE: no second word pending.
  - PEND: second word of a pseudo-instruction held internally.
- cmd_ready = (FSM==IDLE) && !start && (!out_valid || out_ready). Single output register, 1 word/cycle sustained, latency 1 (accepted at edge N, out_valid from N+1).
- Encodings (imm = cmd_imm[15:0]):
  - RTYPE {000000,rs,rt,rd,00000,funct}
  - LW op 100011, SW 101011, LB 100000, SB 101000, BEQ 000100, BNE 000101, ADDI 001000, ANDI 001100, ORI 001101, XORI 001110: {op,rs,rt,imm}
  - J {000010,cmd_imm}
  - JR {000000,rs,15'b0,001000}
  - JALR {000000,rs,00000,rd,00000,001001}
- Pseudo-instructions:
  - BLT word1 = {000000,rs,rt,AT_REG,00000,101010} (slt); word2 = {000101,AT_REG,00000,imm-1} (bne).
  - BGE: same word1; word2 uses beq 000100.
  - Offset is decremented by 1 because word2 sits one word later.
  - On accept, word1 goes to the output register, word2 is stored, FSM→PEND. On the word1 handshake, word2 loads into the output register the same cycle (no bubble), FSM→IDLE.
- Error: BLT/BGE with imm==16'h8000 (imm-1 overflows).
  - Command is consumed, err=1 for one cycle, nothing emitted, address unchanged.
  - All other commands are always legal.
- Addressing:
  - out_addr = address counter value when the word is loaded into the output register.
  - Counter increments by 1 per loaded word and wraps 2^ADDR_W-1→0 silently.
  - word_count increments on each out handshake.
- Stall: out_word/out_addr are held stable while out_valid && !out_ready.
- start (highest priority): out_valid←0, pending word discarded, FSM→IDLE, counter←base_addr, word_count←0. cmd_ready=0 that cycle.
- reset mid-expansion returns everything to reset values immediately.

Test Plan:
- reset, start base_addr=0x10, LW rs=2 rt=3 imm=0x0004, out_ready=1 → next cycle out_word=0x8C430004, out_addr=0x10, word_count=1 after handshake.
- Back-to-back ADDI rs=0 rt=8 imm=0xFFFF then J imm=0x0000010 → 0x2008FFFF @0x10, 0x08000010 @0x11 on consecutive cycles, cmd_ready continuously 1.
- BLT rs=4 rt=5 imm=0x0003, AT_REG=1 → 0x0085082A then 0x14200002 on consecutive addresses; cmd_ready=0 during PEND; BGE same fields → second word 0x10200002.
- BGE imm=0x8000 → err pulse, out_valid stays 0, next command gets the unchanged address.
- out_ready=0 for 3 cycles with JALR rs=31 rd=4 valid → out_word=0x03E02009 held stable, cmd_ready=0; start asserted in PEND of a BLT → out_valid=0, word2 dropped, next word at base_addr.
- ADDR_W=8, base_addr=0xFF, two RTYPE commands → addresses 0xFF then 0x00.
